branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch direction predictor and misprediction resolver for the 5-stage pipeline. It holds a direct-mapped table of 2-bit saturating counters indexed by fetch PC and gives a taken/not-taken prediction to IF combinationally. It consumes the resolved outcome from the EX-stage branch comparator, trains the table, and produces a registered one-cycle misprediction pulse with the corrected PC for the flush/redirect logic.

## Interface
- INDEX_W, 4, table index width; table has 2^INDEX_W entries, indexed by PC[INDEX_W+1:2]
- RESET_STATE, 2'b01, counter value loaded into every entry on reset (weakly not-taken)

- clk_i  input  1  pipeline clock, all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- if_valid_i  input  1  IF holds a valid branch instruction needing prediction
- if_pc_i  input  32  PC of the instruction in IF
- pred_taken_o  output  1  combinational prediction for if_pc_i
- ex_valid_i  input  1  EX holds a resolved conditional branch this cycle
- ex_pc_i  input  32  PC of the branch in EX
- ex_taken_i  input  1  actual outcome from the EX branch comparator
- ex_pred_taken_i  input  1  prediction that was issued for this branch, piped from IF
- ex_target_i  input  32  branch target computed in EX
- mispredict_o  output  1  registered one-cycle flush/redirect pulse
- redirect_pc_o  output  32  correct next PC, valid while mispredict_o is high
- branch_cnt_o  output  32  resolved-branch count (BP_STATS_EN only)
- mispredict_cnt_o  output  32  misprediction count (BP_STATS_EN only)

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is counter[1].
- pred_taken_o = if_valid_i & table[if_pc_i[INDEX_W+1:2]][1]. It is 0 when if_valid_i is 0.
- An accepted update is ex_valid_i & ~mispredict_o. While mispredict_o is high, the instruction in EX is wrong-path. It is ignored: no training, no mispredict, no stats.
- Training on an accepted update at index ex_pc_i[INDEX_W+1:2]:
  - taken: counter +1, saturating at 11
  - not taken: counter −1, saturating at 00
  - This is a 2-bit saturating update with no wrap: 11+taken stays 11, 00+not-taken stays 00.
- Mispredict on an accepted update when ex_taken_i != ex_pred_taken_i:
  - next cycle, mispredict_o=1
  - redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4 (32-bit modulo add, 0xFFFFFFFC+4 wraps to 0)
- redirect_pc_o holds its last value when there is no new mispredict.
- PC bits [1:0] and bits above INDEX_W+1 are ignored. Aliasing branches share a counter.

## Timing
- Reset (async assert, any cycle, including mid-update): every counter = RESET_STATE, mispredict_o=0, redirect_pc_o=0, counters of stats = 0. No update is committed in the cycle reset is asserted.
- Prediction latency: 0 cycles (combinational read).
- Training: table write on the rising edge that ends the EX cycle. It is visible to IF lookups from the next cycle on.
- Same-index read/write in one cycle: IF reads the pre-update value. There is no bypass.
- Mispredict latency: exactly 1 cycle after the EX cycle. mispredict_o is high for exactly 1 cycle.
- Back-to-back: a mispredicting branch in cycle N produces a pulse in N+1. ex_valid_i in N+1 is suppressed, so there is no second pulse in N+2 from that cycle. An accepted branch in N+2 may pulse in N+3.

## Configuration
- BP_STATS_EN defined:
  - branch_cnt_o increments on every accepted update.
  - mispredict_cnt_o increments on every accepted mispredicting update.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
- BP_STATS_EN undefined: both ports are tied to 32'h0 and no counter registers exist. All other behaviour is identical.

## Test plan
- Reset then lookup: if_valid_i=1, if_pc_i=0x00000040 -> pred_taken_o=0 (RESET_STATE 01); mispredict_o=0, redirect_pc_o=0.
- Training to taken, PC 0x40, INDEX_W=4:
  - one taken update with ex_pred_taken_i=0 -> pulse, redirect_pc_o=ex_target_i=0x00000100; lookup 0x40 now predicts 1
  - two more taken updates -> counter 11
  - one not-taken update -> still predicts 1
- Not-taken mispredict: ex_pc_i=0x00000080, ex_taken_i=0, ex_pred_taken_i=1 -> next cycle mispredict_o=1, redirect_pc_o=0x00000084, for 1 cycle only.
- Wrong-path suppression: mispredict in cycle N, then ex_valid_i=1 with a mismatch in N+1 -> mispredict_o=0 in N+2, target counter unchanged, stats unchanged.
- Same-cycle read/write and aliasing:
  - update index 0x1 (PC 0x44) while IF looks up PC 0x44 -> IF sees the old value
  - PC 0x84 (same index) sees the new value next cycle
- Boundary and reset:
  - ex_pc_i=0xFFFFFFFC not-taken mispredict -> redirect_pc_o=0x00000000
  - assert rst_i mid-pulse -> mispredict_o drops immediately and all counters return to 01
  - with BP_STATS_EN, 3 branches / 1 mispredict -> branch_cnt_o=3, mispredict_cnt_o=1

Source files
------------

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch direction predictor with registered mispredict redirect.
// Define BP_STATS_EN to add saturating resolved-branch / misprediction counters.
module branch_predictor #(
  parameter int         INDEX_W     = 4,
  parameter logic [1:0] RESET_STATE = 2'b01
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_valid_i,
  input  logic [31:0] if_pc_i,
  output logic        pred_taken_o,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [1:0]         r_table [DEPTH];
  logic               r_mispredict;
  logic [31:0]        r_redirect;

  logic [INDEX_W-1:0] w_if_idx;
  logic [INDEX_W-1:0] w_ex_idx;
  logic [1:0]         w_ctr;
  logic [1:0]         w_ctr_next;
  logic               w_accept;
  logic               w_mis;
  logic               w_unused;

  assign w_if_idx = if_pc_i[INDEX_W+1:2];
  assign w_ex_idx = ex_pc_i[INDEX_W+1:2];
  assign w_unused = ^{if_pc_i[31:INDEX_W+2], if_pc_i[1:0]};

  assign pred_taken_o = if_valid_i & r_table[w_if_idx][1];

  // Instruction in EX during a redirect pulse is wrong-path and is dropped.
  assign w_accept = ex_valid_i & ~r_mispredict;
  assign w_mis    = w_accept & (ex_taken_i != ex_pred_taken_i);
  assign w_ctr    = r_table[w_ex_idx];

  always_comb begin
    w_ctr_next = w_ctr;
    if (ex_taken_i) begin
      if (w_ctr != 2'b11) w_ctr_next = w_ctr + 2'b01;
    end else begin
      if (w_ctr != 2'b00) w_ctr_next = w_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= RESET_STATE;
      r_mispredict <= 1'b0;
      r_redirect   <= 32'h0;
    end else begin
      if (w_accept) r_table[w_ex_idx] <= w_ctr_next;
      r_mispredict <= w_mis;
      if (w_mis) r_redirect <= ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
    end
  end

  assign mispredict_o  = r_mispredict;
  assign redirect_pc_o = r_redirect;

`ifdef BP_STATS_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mis_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_branch_cnt <= 32'h0;
      r_mis_cnt    <= 32'h0;
    end else begin
      if (w_accept && r_branch_cnt != 32'hFFFF_FFFF)
        r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_mis && r_mis_cnt != 32'hFFFF_FFFF)
        r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign branch_cnt_o     = r_branch_cnt;
  assign mispredict_cnt_o = r_mis_cnt;
`else
  assign branch_cnt_o     = 32'h0;
  assign mispredict_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor against a counter-array model.
// Stats expectations follow BP_STATS_EN as defined for the build.
module tb_branch_predictor;

  localparam int IW = 4;
`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic        pred_taken_o;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_target_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispredict_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain integer counters in 0..3
  int          m_ctr [1<<IW];
  bit          m_mis;
  logic [31:0] m_redir;
  longint      m_br;
  longint      m_mcnt;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_W(IW), .RESET_STATE(2'b01)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i),
    .pred_taken_o(pred_taken_o),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
    .ex_taken_i(ex_taken_i), .ex_pred_taken_i(ex_pred_taken_i),
    .ex_target_i(ex_target_i),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % (1 << IW));
  endfunction

  function automatic bit m_pred(logic [31:0] pc, bit v);
    return v && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic longint sat(longint v);
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < (1<<IW); i++) m_ctr[i] = 1;
    m_mis = 0; m_redir = 0; m_br = 0; m_mcnt = 0;
  endtask

  task automatic drive_ex(bit v, logic [31:0] pc, bit t, bit p,
                          logic [31:0] tgt);
    ex_valid_i = v; ex_pc_i = pc; ex_taken_i = t;
    ex_pred_taken_i = p; ex_target_i = tgt;
  endtask

  // Advance one clock, updating the model from the currently driven inputs.
  task automatic tick();
    bit acc, mis_n;
    int k;
    acc = ex_valid_i && !m_mis;
    mis_n = acc && (ex_taken_i != ex_pred_taken_i);
    if (acc) begin
      k = idx_of(ex_pc_i);
      if (ex_taken_i) m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
      else            m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
      m_br = sat(m_br + 1);
      if (mis_n) m_mcnt = sat(m_mcnt + 1);
    end
    if (mis_n) m_redir = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
    @(posedge clk); #1;
    m_mis = mis_n;
  endtask

  task automatic test_reset();
    if_valid_i = 1; if_pc_i = 32'h40; #1;
    n_cmp++;
    if (pred_taken_o !== 1'b0) begin
      n_err++; $display("FAIL reset_pred got=%0b exp=0", pred_taken_o);
    end
    n_cmp++;
    if (mispredict_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
      n_err++; $display("FAIL reset_outs mis=%0b redir=%h exp=0/0",
                        mispredict_o, redirect_pc_o);
    end
    n_cmp++;
    if (branch_cnt_o !== 32'h0 || mispredict_cnt_o !== 32'h0) begin
      n_err++; $display("FAIL reset_stats br=%0d mis=%0d exp=0/0",
                        branch_cnt_o, mispredict_cnt_o);
    end
  endtask

  task automatic test_train_taken();
    drive_ex(1, 32'h40, 1, 0, 32'h100);
    tick();
    drive_ex(0, 0, 0, 0, 0);
    if_valid_i = 1; if_pc_i = 32'h40; #1;
    n_cmp++;
    if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h100) begin
      n_err++; $display("FAIL train_pulse mis=%0b redir=%h exp=1/00000100",
                        mispredict_o, redirect_pc_o);
    end
    n_cmp++;
    if (pred_taken_o !== 1'b1) begin
      n_err++; $display("FAIL train_pred1 got=%0b exp=1", pred_taken_o);
    end
    tick();
    n_cmp++;
    if (mispredict_o !== 1'b0) begin
      n_err++; $display("FAIL train_pulse_width got=%0b exp=0", mispredict_o);
    end
    for (int i = 0; i < 2; i++) begin
      drive_ex(1, 32'h40, 1, 1, 32'h100);
      tick();
    end
    drive_ex(1, 32'h40, 0, 1, 32'h100);
    tick();
    drive_ex(0, 0, 0, 0, 0); #1;
    n_cmp++;
    if (pred_taken_o !== 1'b1 || m_ctr[idx_of(32'h40)] != 2) begin
      n_err++; $display("FAIL train_sat_dec got=%0b exp=1", pred_taken_o);
    end
    if_valid_i = 0; #1;
    n_cmp++;
    if (pred_taken_o !== 1'b0) begin
      n_err++; $display("FAIL pred_invalid got=%0b exp=0", pred_taken_o);
    end
    tick();
  endtask

  task automatic test_nt_mispredict();
    drive_ex(1, 32'h80, 0, 1, 32'h200);
    tick();
    drive_ex(0, 0, 0, 0, 0);
    n_cmp++;
    if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h84) begin
      n_err++; $display("FAIL nt_pulse mis=%0b redir=%h exp=1/00000084",
                        mispredict_o, redirect_pc_o);
    end
    tick();
    n_cmp++;
    if (mispredict_o !== 1'b0 || redirect_pc_o !== 32'h84) begin
      n_err++; $display("FAIL nt_after mis=%0b redir=%h exp=0/00000084",
                        mispredict_o, redirect_pc_o);
    end
  endtask

  task automatic test_wrong_path();
    longint br0;
    drive_ex(1, 32'h100, 1, 0, 32'h300);
    tick();
    br0 = m_br;
    drive_ex(1, 32'h8C, 1, 0, 32'h400);
    tick();
    drive_ex(0, 0, 0, 0, 0);
    if_valid_i = 1; if_pc_i = 32'h8C; #1;
    n_cmp++;
    if (mispredict_o !== 1'b0 || redirect_pc_o !== 32'h300) begin
      n_err++; $display("FAIL wrong_path_pulse mis=%0b redir=%h exp=0/00000300",
                        mispredict_o, redirect_pc_o);
    end
    n_cmp++;
    if (pred_taken_o !== 1'b0 || m_ctr[3] != 1) begin
      n_err++; $display("FAIL wrong_path_train got=%0b exp=0", pred_taken_o);
    end
    n_cmp++;
    if (branch_cnt_o !== (STATS ? 32'(br0) : 32'h0)) begin
      n_err++; $display("FAIL wrong_path_stats got=%0d exp=%0d",
                        branch_cnt_o, STATS ? br0 : 0);
    end
  endtask

  task automatic test_same_cycle_alias();
    drive_ex(1, 32'h44, 1, 1, 32'h0);
    if_valid_i = 1; if_pc_i = 32'h44; #1;
    n_cmp++;
    if (pred_taken_o !== 1'b0) begin
      n_err++; $display("FAIL same_cycle_old got=%0b exp=0", pred_taken_o);
    end
    tick();
    drive_ex(0, 0, 0, 0, 0);
    if_pc_i = 32'h84; #1;
    n_cmp++;
    if (pred_taken_o !== 1'b1) begin
      n_err++; $display("FAIL alias_new got=%0b exp=1", pred_taken_o);
    end
  endtask

  task automatic test_wrap();
    drive_ex(1, 32'hFFFF_FFFC, 0, 1, 32'h500);
    tick();
    drive_ex(0, 0, 0, 0, 0);
    n_cmp++;
    if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h0) begin
      n_err++; $display("FAIL pc_wrap mis=%0b redir=%h exp=1/00000000",
                        mispredict_o, redirect_pc_o);
    end
    tick();
  endtask

  task automatic test_random(int n);
    for (int i = 0; i < n; i++) begin
      drive_ex($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom);
      if_valid_i = $urandom_range(0, 1);
      if_pc_i = $urandom; #1;
      n_cmp++;
      if (pred_taken_o !== m_pred(if_pc_i, if_valid_i)) begin
        n_err++; $display("FAIL rnd_pred i=%0d pc=%h got=%0b exp=%0b",
                          i, if_pc_i, pred_taken_o, m_pred(if_pc_i, if_valid_i));
      end
      tick();
      n_cmp++;
      if (mispredict_o !== m_mis || redirect_pc_o !== m_redir) begin
        n_err++; $display("FAIL rnd_mis i=%0d mis=%0b redir=%h exp=%0b/%h",
                          i, mispredict_o, redirect_pc_o, m_mis, m_redir);
      end
      n_cmp++;
      if (branch_cnt_o !== (STATS ? 32'(m_br) : 32'h0) ||
          mispredict_cnt_o !== (STATS ? 32'(m_mcnt) : 32'h0)) begin
        n_err++; $display("FAIL rnd_stats i=%0d br=%0d mis=%0d exp=%0d/%0d", i,
                          branch_cnt_o, mispredict_cnt_o,
                          STATS ? m_br : 0, STATS ? m_mcnt : 0);
      end
    end
    drive_ex(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid_pulse();
    drive_ex(1, 32'h54, 1, 1, 32'h0);
    tick();
    drive_ex(1, 32'h54, 1, 0, 32'h600);
    tick();
    drive_ex(0, 0, 0, 0, 0);
    n_cmp++;
    if (mispredict_o !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_pulse got=%0b exp=1", mispredict_o);
    end
    #2 rst_i = 1; #1;
    m_reset();
    n_cmp++;
    if (mispredict_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
      n_err++; $display("FAIL async_reset mis=%0b redir=%h exp=0/0",
                        mispredict_o, redirect_pc_o);
    end
    @(posedge clk); #2 rst_i = 0;
    n_cmp++;
    if (branch_cnt_o !== 32'h0 || mispredict_cnt_o !== 32'h0) begin
      n_err++; $display("FAIL reset_stats2 br=%0d mis=%0d exp=0/0",
                        branch_cnt_o, mispredict_cnt_o);
    end
    if_valid_i = 1;
    for (int k = 0; k < (1<<IW); k++) begin
      if_pc_i = 32'(k) << 2; #1;
      n_cmp++;
      if (pred_taken_o !== 1'b0) begin
        n_err++; $display("FAIL reset_table idx=%0d got=%0b exp=0", k, pred_taken_o);
      end
    end
    // One taken step from 01 must reach weak-taken.
    @(posedge clk); #1;
    drive_ex(1, 32'h54, 1, 0, 32'h0);
    tick();
    drive_ex(0, 0, 0, 0, 0);
    if_pc_i = 32'h54; #1;
    n_cmp++;
    if (pred_taken_o !== 1'b1) begin
      n_err++; $display("FAIL reset_state_01 got=%0b exp=1", pred_taken_o);
    end
    tick();
  endtask

  task automatic test_stats();
    longint b0, m0;
    b0 = m_br; m0 = m_mcnt;
    drive_ex(1, 32'h60, 0, 0, 32'h0); tick();
    drive_ex(1, 32'h64, 1, 0, 32'h700); tick();
    drive_ex(0, 0, 0, 0, 0); tick();
    drive_ex(1, 32'h68, 0, 0, 32'h0); tick();
    drive_ex(0, 0, 0, 0, 0); #1;
    n_cmp++;
    if (branch_cnt_o !== (STATS ? 32'(b0 + 3) : 32'h0) ||
        mispredict_cnt_o !== (STATS ? 32'(m0 + 1) : 32'h0)) begin
      n_err++; $display("FAIL stats_3_1 br=%0d mis=%0d exp=%0d/%0d",
                        branch_cnt_o, mispredict_cnt_o,
                        STATS ? b0 + 3 : 0, STATS ? m0 + 1 : 0);
    end
  endtask

  initial begin
    rst_i = 1; if_valid_i = 0; if_pc_i = 0;
    drive_ex(0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #2 rst_i = 0;
    @(posedge clk); #1;
    test_reset();
    test_train_taken();
    test_nt_mispredict();
    test_wrong_path();
    tick();
    test_same_cycle_alias();
    test_wrap();
    test_random(400);
    test_reset_mid_pulse();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
